// File: rtl/bk_mp_add_seq.sv
// bk_mp_add_seq
// Multi-precision add/subtract sequencer. It time-shares one external 32-bit
// combinational adder and feeds it one limb per cycle, least-significant limb
// first. The carry between limbs is chained through a register.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready never depends on valid. A producer holds its payload
// stable while valid=1 and ready=0.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   in_a, in_b          WORDS x 32-bit operands; limb i is bits [32i+31:32i]
//   in_cin              carry-in for add mode (ignored when in_sub=1)
//   in_sub              1: A-B, 0: A+B+cin
//   add_a/add_b/add_cin limb operands to the external adder (0 outside RUN)
//   add_sum/add_cout    combinational return from the external adder
//   out_valid/out_ready result handshake
//   out_sum, out_cout   result and final carry (1 = no borrow when subtracting)
//   busy                high in RUN or DONE
module bk_mp_add_seq #(
  parameter int WORDS = 4,
  parameter int IDXW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
);

  localparam int SELW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WORDS-1:0][31:0] a_reg;
  logic [WORDS-1:0][31:0] b_reg;
  logic [WORDS-1:0][31:0] sum_reg;
  logic                   carry;
  logic [IDXW-1:0]        idx;
  logic [SELW-1:0]        sel;

  // Only the low bits of idx address a limb. idx stays within 0..WORDS-1.
  assign sel = idx[SELW-1:0];

  assign out_sum  = sum_reg;
  assign out_cout = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[sel];
        add_b   = b_reg[sel];
        add_cin = carry;
        if (idx == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + 1. B is inverted when it is latched, and the +1
  // goes in as the initial carry. The RUN datapath is therefore the same for
  // both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
            carry <= in_sub | in_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[sel] <= add_sum;
          carry        <= add_cout;
          if (idx != LAST) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/bk_mp_add_seq.md
Name: bk_mp_add_seq

Overview:
- Multi-precision add/subtract sequencer that time-shares one external 32-bit Brent-Kung adder (BK_adder32bit).
- Accepts a WORDS×32-bit operand pair over a valid/ready handshake.
- Drives the adder one 32-bit word per cycle, least-significant word first, chaining the carry in a register.
- Returns the full-width result over a second valid/ready handshake.

Parameters:
- WORDS, 4, number of 32-bit limbs per operand (legal range 2..16).
- IDXW, 4, width of the limb index counter; must satisfy 2^IDXW >= WORDS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request operands valid.
- in_ready  output  1  block can accept a request.
- in_a  input  32*WORDS  operand A; limb i is bits [32i+31:32i].
- in_b  input  32*WORDS  operand B.
- in_cin  input  1  carry-in for add mode; ignored in subtract mode.
- in_sub  input  1  1 = A-B, 0 = A+B+cin.
- add_a  output  32  limb to adder input a.
- add_b  output  32  limb to adder input b (inverted in subtract mode).
- add_cin  output  1  carry to adder.
- add_sum  input  32  adder sum (combinational return).
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  32*WORDS  result.
- out_cout  output  1  final carry; in subtract mode 1 = no borrow (A>=B).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=IDLE, idx=0, carry=0.
  - All operand and result registers cleared.
  - out_valid=0, out_sum=0, out_cout=0, busy=0.
  - add_a, add_b, add_cin driven 0.
  - in_ready=1 once rst_n=1.
  - Reset mid-operation discards the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid && in_ready at a rising edge T.
  - On accept: latch in_a into a_reg, latch in_b into b_reg (bitwise inverted if in_sub=1), carry <= in_sub ? 1 : in_cin, idx <= 0, state <= RUN.
- RUN:
  - in_ready=0.
  - add_a = a_reg limb idx, add_b = b_reg limb idx, add_cin = carry.
  - Each edge: sum_reg limb idx <= add_sum, carry <= add_cout.
  - If idx == WORDS-1 then state <= DONE, else idx <= idx+1.
  - The adder is treated as purely combinational; single-cycle limb path.
- DONE:
  - out_valid=1; out_sum=sum_reg and out_cout=carry, both held stable while out_ready=0.
  - On out_valid && out_ready edge: state <= IDLE, out_valid <= 0.
- Outside RUN: add_a, add_b, add_cin are 0.
- Latency:
  - out_valid rises at edge T+WORDS.
  - Minimum accept-to-accept spacing is WORDS+2 cycles (one DONE cycle and one IDLE cycle with out_ready=1).
- in_valid while not in IDLE: ignored, not queued. The requester must hold its operands until in_ready.
- Inputs change during RUN: no effect; operands come from the latched registers.
- Arithmetic:
  - Result is modulo 2^(32*WORDS).
  - out_cout is the carry-out of the top limb.
  - Subtract is A + ~B + 1 (two's complement).
- idx never exceeds WORDS-1 and does not wrap within an operation.

Test Plan (WORDS=4):
- Carry into limb 1: A=0x00000000_00000000_00000000_FFFFFFFF, B=1, add, cin=0 -> out_sum=0x00000000_00000000_00000001_00000000, out_cout=0, out_valid rises 4 edges after accept.
- Full ripple: A=all-ones, B=0, cin=1 -> out_sum=0, out_cout=1; also A=all-ones, B=all-ones, cin=1 -> out_sum=all-ones, out_cout=1.
- Subtract:
  - A=5, B=7, sub=1 -> out_sum=0xFFFF...FFFE (128 bits), out_cout=0.
  - A=7, B=5 -> out_sum=2, out_cout=1.
  - in_cin=1 with sub=1 must not change either result.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, pulsing in_valid with new operands -> out_sum/out_cout stable, in_ready=0, new request not accepted; accepted only after the out_ready handshake and the return to IDLE.
- Async reset mid-RUN: assert rst_n=0 two cycles after accept -> out_valid, out_sum, busy and add_* go 0 immediately without a clock edge; after release in_ready=1; next op (A=0x1234, B=0x10) -> out_sum=0x1244.
- Back-to-back with in_valid and out_ready tied 1: 8 random operand pairs -> each result matches a reference model; accepts exactly 6 cycles apart; add_* is 0 outside RUN.
